serializer_array: RTL and testbench
===================================

# serializer_array

Multi-channel, parametrised parallel-to-serial converter that drives NUM_CHANNELS serial data lines from one word-wide stream input. It generates its own bit clock and frame-load strobe from the system clock, and launches data on the falling edge of that bit clock for board-level timing. It sits between the FPGA-side sample FIFO and the isolator/converter serial links. It adds a ready/valid input, a one-frame holding buffer, continuous framing, and underrun handling.

## Interface
Parameters:
- NUM_CHANNELS, 4: number of serial lanes.
- WIDTH, 8: bits per word per lane; must be ≥ 2.
- CLK_DIV, 4: clk cycles per sclk period; must be even and ≥ 2.
- DEFAULT_VAL, 1: idle and fill level driven on sdata.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  frames are generated while high.
- in_valid  in  1  in_data holds a frame.
- in_ready  out  1  holding buffer can accept a frame.
- in_data  in  NUM_CHANNELS*WIDTH  lane c word is bits [c*WIDTH +: WIDTH].
- sclk  out  1  generated bit clock.
- sload_n  out  1  low for the first bit slot of every frame.
- sdata  out  NUM_CHANNELS  serial data, MSB first.
- busy  out  1  high in RUN.
- underrun  out  1  one-clk pulse when a frame starts with the buffer empty.
- underrun_count  out  16  saturating underrun count; present only with the macro.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1, wraps, and runs continuously out of reset.
  - sclk = (div_cnt < CLK_DIV/2), registered.
  - Fall tick: the clk cycle on which div_cnt becomes CLK_DIV/2.
  - All sdata, sload_n and bit-slot updates occur only on fall ticks.
- Holding buffer: one frame deep.
  - Handshake: in_valid && in_ready stores in_data and sets buf_full.
  - in_ready is registered and equals !buf_full.
- bit_cnt: counts slots 0..WIDTH-1 within a frame.
- States:
  - IDLE: sdata = all DEFAULT_VAL, sload_n = 1, busy = 0. On a fall tick with enable && buf_full: go to RUN, start a frame (slot 0).
  - RUN: on each fall tick, advance bit_cnt. At slot 0:
    - Buffer full: load per-lane shift registers from the buffer and clear buf_full.
    - Buffer empty: load all lanes with WIDTH copies of DEFAULT_VAL and pulse underrun.
    - sdata takes the shift register MSB on each fall tick; the shift register moves left, filling with DEFAULT_VAL.
    - sload_n = 0 during slot 0 only.
  - End of frame (fall tick after slot WIDTH-1):
    - enable low: return to IDLE; sdata returns to DEFAULT_VAL; a full buffer is retained.
    - Otherwise: start the next frame immediately, with no gap.
- Simultaneous handshake and slot-0 load: cannot occur in the same cycle, because in_ready = 0 while buf_full. A new frame is accepted the cycle after the load clears buf_full.
- enable deasserted mid-frame: the current frame completes.

## Timing
- Reset values: sclk=1, sload_n=1, sdata=all DEFAULT_VAL, in_ready=0, busy=0, underrun=0, underrun_count=0, div_cnt=0, buf_full=0, state=IDLE.
- in_ready rises the first clk after reset_n deasserts.
- Reset asserted mid-frame: all state returns to reset values on the next clk edge, the buffered frame is discarded, and no partial frame resumes.
- Frame length: WIDTH*CLK_DIV clk cycles; sload_n is low for CLK_DIV cycles.
- Latency from IDLE: the accepted frame's MSB appears at the first fall tick at least one clk after the handshake. Worst case is CLK_DIV+1 clk cycles.
- underrun and the default-fill frame start on the same fall tick.
- Sustained throughput requires one handshake per frame, occurring after that frame's slot-0 load.

## Configuration
- SERIALIZER_ARRAY_UNDERRUN_COUNT_EN:
  - Defined: the underrun_count port exists. It increments on each underrun pulse, saturates at 16'hFFFF, and clears only on reset.
  - Undefined: the port and its counter are absent; the underrun pulse is unchanged.

## Test plan
Bench parameters for all cases: NUM_CHANNELS=2, WIDTH=8, CLK_DIV=4, DEFAULT_VAL=1.
- Reset release, enable=1, no input → sdata=2'b11, sload_n=1, busy=0, sclk toggles every 2 clk, in_ready=1 one clk after release.
- One frame, in_data=16'hA55A (lane1=A5, lane0=5A) → sload_n low for 4 clk; over 8 fall ticks lane1 shows 1,0,1,0,0,1,0,1 and lane0 shows 0,1,0,1,1,0,1,0; each bit changes only on sclk falling edges.
- Back-to-back frames 16'h00FF then 16'hFF00, each offered as soon as in_ready rises → contiguous 64-clk output with no gap; sload_n low at clk 0 and clk 32 of the burst.
- Starve after one frame with enable=1 → the second frame is all-1 fill, underrun pulses once for 1 clk, and underrun_count=1 when the macro is defined.
- Drop enable at slot 3 → the frame finishes all 8 bits, then IDLE, busy=0, sdata=2'b11. Separately, assert reset_n=0 at slot 3 → all outputs take reset values on the next clk edge.

Source files
------------

// File: rtl/serializer_array_if.sv
// Word-stream input and serial-link output bundle for serializer_array.
// underrun_count exists only when SERIALIZER_ARRAY_UNDERRUN_COUNT_EN is defined.
interface serializer_array_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int WIDTH        = 8
);
    logic                          enable;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CHANNELS*WIDTH-1:0] in_data;
    logic                          sclk;
    logic                          sload_n;
    logic [NUM_CHANNELS-1:0]       sdata;
    logic                          busy;
    logic                          underrun;
`ifdef SERIALIZER_ARRAY_UNDERRUN_COUNT_EN
    logic [15:0]                   underrun_count;

    modport master (
        output enable, in_valid, in_data,
        input  in_ready, sclk, sload_n, sdata, busy, underrun, underrun_count
    );
    modport slave (
        input  enable, in_valid, in_data,
        output in_ready, sclk, sload_n, sdata, busy, underrun, underrun_count
    );
`else
    modport master (
        output enable, in_valid, in_data,
        input  in_ready, sclk, sload_n, sdata, busy, underrun
    );
    modport slave (
        input  enable, in_valid, in_data,
        output in_ready, sclk, sload_n, sdata, busy, underrun
    );
`endif
endinterface

// File: rtl/serializer_array.sv
// Multi-lane parallel-to-serial converter with its own sclk/sload_n; optional counter via SERIALIZER_ARRAY_UNDERRUN_COUNT_EN.
// Latency: accepted word's MSB appears on the first sclk fall at least 1 clk after handshake (<= CLK_DIV+1 clk).
// Backpressure: one-frame holding buffer; in_ready low while it is full, empty buffer at frame start sends fill.
module serializer_array #(
    parameter int   NUM_CHANNELS = 4,
    parameter int   WIDTH        = 8,
    parameter int   CLK_DIV      = 4,
    parameter logic DEFAULT_VAL  = 1'b1
) (
    input logic              clk,
    input logic              reset_n,
    serializer_array_if.slave bus
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] FILL_WORD = {WIDTH{DEFAULT_VAL}};
    localparam logic [NUM_CHANNELS-1:0] IDLE_LINES = {NUM_CHANNELS{DEFAULT_VAL}};

    typedef enum logic {IDLE, RUN} state_t;
    typedef logic [NUM_CHANNELS-1:0][WIDTH-1:0] frame_t;

    state_t                  state_q;
    logic [DW-1:0]           div_cnt_q, div_cnt_d;
    logic [BW-1:0]           bit_cnt_q;
    frame_t                  buf_q, buf_d, shreg_q, shreg_d, shift_src;
    logic                    buf_full_q, buf_full_d;
    logic                    in_ready_q, sclk_q, sload_n_q, busy_q, underrun_q;
    logic [NUM_CHANNELS-1:0] sdata_q, sdata_d;
    logic                    fall_tick, frame_end, frame_start, handshake;

    always_comb begin
        div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        fall_tick   = (div_cnt_d == DIV_HALF);
        frame_end   = (state_q == RUN) && (bit_cnt_q == BIT_LAST);
        // From IDLE a frame only starts with data; in RUN an empty buffer starts a fill frame.
        frame_start = fall_tick && bus.enable && (frame_end || (state_q == IDLE && buf_full_q));
        handshake   = bus.in_valid && in_ready_q;

        buf_d      = handshake ? frame_t'(bus.in_data) : buf_q;
        buf_full_d = buf_full_q;
        if (frame_start) buf_full_d = 1'b0;
        if (handshake)   buf_full_d = 1'b1;

        shift_src = shreg_q;
        if (frame_start) shift_src = buf_full_q ? buf_q : {NUM_CHANNELS{FILL_WORD}};
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sdata_d[c] = shift_src[c][WIDTH-1];
            shreg_d[c] = {shift_src[c][WIDTH-2:0], DEFAULT_VAL};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q  <= '0;
            sclk_q     <= 1'b1;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sclk_q     <= (div_cnt_d < DIV_HALF);
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            in_ready_q <= !buf_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            sdata_q    <= IDLE_LINES;
            sload_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (frame_start) begin
                state_q    <= RUN;
                busy_q     <= 1'b1;
                bit_cnt_q  <= '0;
                sload_n_q  <= 1'b0;
                underrun_q <= !buf_full_q;
                sdata_q    <= sdata_d;
                shreg_q    <= shreg_d;
            end else if (fall_tick && frame_end) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                sload_n_q <= 1'b1;
                sdata_q   <= IDLE_LINES;
            end else if (fall_tick && state_q == RUN) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                sload_n_q <= 1'b1;
                sdata_q   <= sdata_d;
                shreg_q   <= shreg_d;
            end
        end
    end

`ifdef SERIALIZER_ARRAY_UNDERRUN_COUNT_EN
    logic [15:0] urun_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            urun_cnt_q <= '0;
        end else if (frame_start && !buf_full_q && urun_cnt_q != 16'hFFFF) begin
            urun_cnt_q <= urun_cnt_q + 16'd1;
        end
    end

    assign bus.underrun_count = urun_cnt_q;
`endif

    assign bus.in_ready = in_ready_q;
    assign bus.sclk     = sclk_q;
    assign bus.sload_n  = sload_n_q;
    assign bus.sdata    = sdata_q;
    assign bus.busy     = busy_q;
    assign bus.underrun = underrun_q;
endmodule

// File: tb/tb_serializer_array.sv
// Directed bench for serializer_array with 2 lanes, 8-bit words, CLK_DIV=4.
module tb_serializer_array;
    localparam int NCH = 2;
    localparam int W   = 8;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serializer_array_if #(.NUM_CHANNELS(NCH), .WIDTH(W)) bus ();

    serializer_array #(
        .NUM_CHANNELS(NCH),
        .WIDTH       (W),
        .CLK_DIV     (DIV),
        .DEFAULT_VAL (1'b1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        logic        in_valid;
        logic [15:0] in_data;
        logic        exp_sclk;
        logic        exp_rdy;
        logic [1:0]  exp_sdata;
        logic        exp_sload_n;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, ".sclk"},     32'(bus.sclk),     32'd1);
        chk({name, ".sload_n"},  32'(bus.sload_n),  32'd1);
        chk({name, ".sdata"},    32'(bus.sdata),    32'd3);
        chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({name, ".busy"},     32'(bus.busy),     32'd0);
        chk({name, ".underrun"}, 32'(bus.underrun), 32'd0);
`ifdef SERIALIZER_ARRAY_UNDERRUN_COUNT_EN
        chk({name, ".urun_cnt"}, 32'(bus.underrun_count), 32'd0);
`endif
    endtask

    // exp_bits holds the 2-bit sdata expected per slot, slot 0 in the top two bits.
    task automatic run_frame(input string name, input logic [15:0] exp_bits, input logic exp_ur,
                             input int ncyc, input logic offer, input logic [15:0] offer_dat,
                             input int drop_en_at);
        logic [15:0] sh;
        logic [1:0]  exp_sd;
        for (int i = 0; i < ncyc; i++) begin
            step();
            sh     = exp_bits << (2 * (i / DIV));
            exp_sd = sh[15:14];
            chk({name, ".sdata"},    32'(bus.sdata),    32'(exp_sd));
            chk({name, ".sload_n"},  32'(bus.sload_n),  (i < DIV) ? 32'd0 : 32'd1);
            chk({name, ".busy"},     32'(bus.busy),     32'd1);
            chk({name, ".sclk"},     32'(bus.sclk),     ((i % DIV) >= DIV / 2) ? 32'd1 : 32'd0);
            chk({name, ".underrun"}, 32'(bus.underrun), (i == 0 && exp_ur) ? 32'd1 : 32'd0);
            if (offer && i == 0) begin
                chk({name, ".rdy_open"}, 32'(bus.in_ready), 32'd1);
                bus.in_valid = 1'b1;
                bus.in_data  = offer_dat;
            end
            if (offer && i == 1) begin
                chk({name, ".rdy_shut"}, 32'(bus.in_ready), 32'd0);
                bus.in_valid = 1'b0;
            end
            if (i == drop_en_at) bus.enable = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 16'hA55A, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0};

        reset_n      = 1'b0;
        bus.enable   = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) step();
        chk_reset("reset");

        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.in_valid = vecs[k].in_valid;
            bus.in_data  = vecs[k].in_data;
            step();
            chk("vec.sclk",     32'(bus.sclk),     32'(vecs[k].exp_sclk));
            chk("vec.in_ready", 32'(bus.in_ready), 32'(vecs[k].exp_rdy));
            chk("vec.sdata",    32'(bus.sdata),    32'(vecs[k].exp_sdata));
            chk("vec.sload_n",  32'(bus.sload_n),  32'(vecs[k].exp_sload_n));
            chk("vec.busy",     32'(bus.busy),     32'(vecs[k].exp_busy));
        end
        bus.in_valid = 1'b0;

        run_frame("a55a", 16'h9966, 1'b0, 32, 1'b0, 16'h0000, -1);
        run_frame("fill", 16'hFFFF, 1'b1, 32, 1'b1, 16'h00FF, -1);
`ifdef SERIALIZER_ARRAY_UNDERRUN_COUNT_EN
        chk("urun_cnt.one", 32'(bus.underrun_count), 32'd1);
`endif
        run_frame("00ff", 16'h5555, 1'b0, 32, 1'b1, 16'hFF00, -1);
        run_frame("ff00", 16'hAAAA, 1'b0, 32, 1'b1, 16'h3CC3, 12);

        step();
        chk("stop.busy",     32'(bus.busy),     32'd0);
        chk("stop.sdata",    32'(bus.sdata),    32'd3);
        chk("stop.sload_n",  32'(bus.sload_n),  32'd1);
        chk("stop.in_ready", 32'(bus.in_ready), 32'd0);
        chk("stop.underrun", 32'(bus.underrun), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle.busy",     32'(bus.busy),     32'd0);
            chk("idle.in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.enable = 1'b1;

        run_frame("3cc3", 16'h5AA5, 1'b0, 13, 1'b1, 16'h1234, -1);
        reset_n = 1'b0;
        step();
        chk_reset("midreset");
        reset_n = 1'b1;
        step();
        chk("rel.in_ready", 32'(bus.in_ready), 32'd1);
        for (int k = 0; k < 40; k++) begin
            step();
            chk("post.busy",     32'(bus.busy),     32'd0);
            chk("post.sdata",    32'(bus.sdata),    32'd3);
            chk("post.underrun", 32'(bus.underrun), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
